fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_arb_rr_pick.sv | 33 +++
 rtl/fifo_push_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo push arbiter.
// The stall counter is only built when FIFO_ARB_STALL_CNT_EN is defined.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set request above last_owner, wrapping.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        // Offset 1 first so the previous owner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found          = 1'b1;
                pick[cand]     = 1'b1;
                pick_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter feeding one fifo push port from NUM_REQ requesters.
// Optional owner-stall counter enabled by defining FIFO_ARB_STALL_CNT_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// BURST | one owner in o_grant; push up to BURST_LEN words
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic                         i_fifo_full,
    output logic                         o_push,
    output logic [BIT_WIDTH-1:0]         o_push_data,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [STALL_CNT_W-1:0]       o_stall_cnt
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = 8;

    arb_state_t         state;
    logic               run_en;
    logic [IDX_W-1:0]   owner_idx;
    logic [IDX_W-1:0]   last_owner;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic               last_beat;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (i_req_valid),
        .last_owner (last_owner),
        .pick       (pick),
        .pick_idx   (pick_idx)
    );

    assign owner_valid = |(i_req_valid & o_grant);
    assign o_req_ready = o_grant & {NUM_REQ{~i_fifo_full}};
    assign o_push      = |(i_req_valid & o_req_ready);
    assign last_beat   = (beat_cnt == BEAT_W'(BURST_LEN - 1));

    always_comb begin
        o_push_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) begin
                o_push_data = o_push_data | i_req_data[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // run_en holds the FSM idle for the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_en     <= 1'b0;
            state      <= IDLE;
            o_grant    <= '0;
            owner_idx  <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else if (!run_en) begin
            run_en <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_req_valid) begin
                        state     <= BURST;
                        o_grant   <= pick;
                        owner_idx <= pick_idx;
                    end
                end
                BURST: begin
                    if (!owner_valid || (o_push && last_beat)) begin
                        state      <= IDLE;
                        o_grant    <= '0;
                        last_owner <= owner_idx;
                        beat_cnt   <= '0;
                    end else if (o_push) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state == BURST) && owner_valid && i_fifo_full
                     && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: directed scenarios plus random traffic
// checked against a requester/owner level reference model.
module tb_fifo_push_arbiter;

    localparam int BW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     i_req_valid;
    logic [NR*BW-1:0]  i_req_data;
    logic [NR-1:0]     o_req_ready;
    logic              i_fifo_full;
    logic              o_push;
    logic [BW-1:0]     o_push_data;
    logic [NR-1:0]     o_grant;
    logic [15:0]       o_stall_cnt;

    fifo_push_arbiter #(
        .BIT_WIDTH (BW),
        .NUM_REQ   (NR),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .i_fifo_full (i_fifo_full),
        .o_push      (o_push),
        .o_push_data (o_push_data),
        .o_grant     (o_grant),
        .o_stall_cnt (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] grant;
        logic [NR-1:0] ready;
        logic          push;
        logic [BW-1:0] data;
        logic [15:0]   stall;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Sources: remaining words, next word number, and a valid gate per requester.
    int rem [NR];
    int word[NR];
    bit gate[NR];

    // Reference model: owner index (-1 = nobody), round-robin pointer, beats.
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_beats = 0;
    int m_stall = 0;
    bit m_hold  = 1'b1;

    int dut_pushes = 0;
    int glog[$];
    logic [NR-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for stimulus condition", name);
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] g);
        int r = -1;
        for (int k = 0; k < NR; k++) if (g[k]) r = k;
        return r;
    endfunction

    // One clock cycle: drive, record expectation, advance the model.
    task automatic step(input bit rst, input bit full);
        logic [NR-1:0]    v;
        logic [NR*BW-1:0] d;
        exp_t             e;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            v[k]          = (rem[k] > 0) && gate[k];
            d[k*BW +: BW] = BW'(k * 64 + word[k]);
        end
        reset_n     = ~rst;
        i_req_valid = v;
        i_req_data  = d;
        i_fifo_full = full;

        e.grant = '0;
        e.ready = '0;
        e.push  = 1'b0;
        e.data  = '0;
        e.stall = rst ? 16'd0 : 16'(m_stall);
        if (!rst && m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.ready          = full ? '0 : e.grant;
            e.push           = v[m_owner] && !full;
            e.data           = d[m_owner*BW +: BW];
        end
        q.push_back(e);

        if (rst) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_beats = 0;
            m_stall = 0;
            m_hold  = 1'b1;
        end else if (m_hold) begin
            m_hold = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= NR; i++) begin
                if (m_owner < 0 && v[(m_last + i) % NR]) m_owner = (m_last + i) % NR;
            end
        end else if (!v[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_beats = 0;
        end else if (full) begin
`ifdef FIFO_ARB_STALL_CNT_EN
            if (m_stall < 65535) m_stall++;
`endif
        end else begin
            rem[m_owner]--;
            word[m_owner]++;
            m_beats++;
            if (m_beats == BL) begin
                m_last  = m_owner;
                m_owner = -1;
                m_beats = 0;
            end
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("grant", 32'(o_grant), 32'(e.grant));
            check("ready", 32'(o_req_ready), 32'(e.ready));
            check("push", 32'(o_push), 32'(e.push));
            check("push_data", 32'(o_push_data), 32'(e.data));
            check("stall_cnt", 32'(o_stall_cnt), 32'(e.stall));
        end
        if (o_push) dut_pushes++;
        if (o_grant != '0 && o_grant != prev_grant) glog.push_back(onehot_idx(o_grant));
        prev_grant = o_grant;
    end

    task automatic clear_logs();
        dut_pushes = 0;
        glog.delete();
    endtask

    task automatic run_to_beats(input int target, input string name);
        int n = 0;
        while (m_beats != target && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (m_beats != target) timeout(name);
    endtask

    initial begin
        int          exp2[5];
        logic [15:0] s0;
        reset_n     = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        i_fifo_full = 1'b0;
        for (int k = 0; k < NR; k++) begin
            rem[k]  = 0;
            word[k] = 1;
            gate[k] = 1'b1;
        end

        repeat (3) step(1'b1, 1'b0);
        check("reset_grant", 32'(o_grant), 32'd0);
        check("reset_stall", 32'(o_stall_cnt), 32'd0);

        // Single requester, 6 words: 4-word burst, idle gap, 2-word burst.
        clear_logs();
        rem[0] = 6;
        repeat (20) step(1'b0, 1'b0);
        check("p1_pushes", 32'(dut_pushes), 32'd6);
        check("p1_ngrants", 32'(glog.size()), 32'd2);
        check("p1_grant0", 32'(glog[0]), 32'd0);
        check("p1_grant1", 32'(glog[1]), 32'd0);

        // All four requesting: round-robin order from req0.
        repeat (2) step(1'b1, 1'b0);
        clear_logs();
        for (int k = 0; k < NR; k++) rem[k] = 8;
        repeat (45) step(1'b0, 1'b0);
        exp2 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("p2_order", 32'(glog[i]), 32'(exp2[i]));
        check("p2_pushes", 32'(dut_pushes), 32'd32);

        // Full stall mid-burst on req1.
        rem[1] = 6;
        run_to_beats(2, "p3_setup");
        s0 = o_stall_cnt;
        clear_logs();
        repeat (5) step(1'b0, 1'b1);
        check("p3_stall_pushes", 32'(dut_pushes), 32'd0);
        check("p3_held_grant", 32'(o_grant), 32'b0010);
        check("p3_no_regrant", 32'(glog.size()), 32'd0);
        step(1'b0, 1'b0);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("p3_stall_delta", 32'(o_stall_cnt - s0), 32'd5);
`else
        check("p3_stall_zero", 32'(o_stall_cnt), 32'd0);
`endif
        clear_logs();
        repeat (10) step(1'b0, 1'b0);
        check("p3_after_pushes", 32'(dut_pushes), 32'd3);

        // Owner req2 drops valid after 2 words; req3 waiting.
        clear_logs();
        rem[2] = 2;
        rem[3] = 4;
        repeat (12) step(1'b0, 1'b0);
        check("p4_ngrants", 32'(glog.size()), 32'd2);
        check("p4_first", 32'(glog[0]), 32'd2);
        check("p4_second", 32'(glog[1]), 32'd3);
        check("p4_pushes", 32'(dut_pushes), 32'd6);

        // Reset mid-burst after 2 pushes.
        rem[1] = 10;
        run_to_beats(2, "p5_setup");
        step(1'b1, 1'b0);
        check("p5_rst_push", 32'(o_push), 32'd0);
        check("p5_rst_grant", 32'(o_grant), 32'd0);
        check("p5_rst_ready", 32'(o_req_ready), 32'd0);
        step(1'b1, 1'b0);
        clear_logs();
        rem[0] = 3;
        repeat (10) step(1'b0, 1'b0);
        check("p5_first_after_rst", 32'(glog[0]), 32'd0);

        // Random traffic with valid drop-outs, full stalls and occasional reset.
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < NR; k++) begin
                if (rem[k] == 0 && $urandom_range(3) == 0) rem[k] = $urandom_range(6, 1);
                gate[k] = ($urandom_range(9) != 0);
            end
            step($urandom_range(199) == 0, $urandom_range(3) == 0);
        end

        for (int k = 0; k < NR; k++) rem[k] = 0;
        repeat (4) step(1'b0, 1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
